// File: rtl/bcd_to_bin.sv
// Six-digit BCD to 20-bit binary by reverse double-dabble; 20 clocks start-to-done (1 clock for a rejected request).
// No backpressure: start is accepted only when idle, and a start while busy is dropped.
module bcd_to_bin (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [3:0]  unit,
    input  logic [3:0]  ten,
    input  logic [3:0]  hun,
    input  logic [3:0]  tho,
    input  logic [3:0]  t_tho,
    input  logic [3:0]  h_hun,
    output logic [19:0] data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic {IDLE, CONV} state_t;

    state_t      state;
    logic [4:0]  step_cnt;
    logic [43:0] sreg;
    logic [43:0] shifted;
    logic [43:0] stepped;
    logic        bad_digit;

    assign bad_digit = (unit > 4'd9) || (ten > 4'd9) || (hun > 4'd9) ||
                       (tho > 4'd9) || (t_tho > 4'd9) || (h_hun > 4'd9);

    // One reverse double-dabble step: shift right, then pull each BCD field >= 8 down by 3.
    always_comb begin
        shifted = {1'b0, sreg[43:1]};
        stepped = shifted;
        for (int i = 0; i < 6; i++) begin
            if (shifted[20 + 4*i + 3]) begin
                stepped[20 + 4*i +: 4] = shifted[20 + 4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            step_cnt <= 5'd0;
            sreg     <= 44'd0;
            data     <= 20'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            sreg     <= {h_hun, t_tho, tho, hun, ten, unit, 20'd0};
                            step_cnt <= 5'd0;
                            busy     <= 1'b1;
                            state    <= CONV;
                        end
                    end
                end
                CONV: begin
                    sreg     <= stepped;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == 5'd19) begin
                        data  <= stepped[19:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and randomized checks of bcd_to_bin against a decimal-arithmetic reference.
module tb_bcd_to_bin;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  unit = 4'd0, ten = 4'd0, hun = 4'd0, tho = 4'd0, t_tho = 4'd0, h_hun = 4'd0;
    logic [19:0] data;
    logic        busy, done, err;

    int passed = 0;
    int total  = 0;
    int exp_data = 0;

    bcd_to_bin dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .unit      (unit),
        .ten       (ten),
        .hun       (hun),
        .tho       (tho),
        .t_tho     (t_tho),
        .h_hun     (h_hun),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_digits(input logic [23:0] d);
        {h_hun, t_tho, tho, hun, ten, unit} = d;
    endtask

    function automatic int model(input logic [23:0] d);
        int v = 0;
        for (int i = 5; i >= 0; i--) v = v * 10 + int'(d[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [23:0] rand_valid();
        logic [23:0] d;
        for (int i = 0; i < 6; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
        return d;
    endfunction

    // Issues a valid request and returns in the cycle where done is high.
    task automatic run_valid(input logic [23:0] d, input string tag, input int poke_at);
        int lat = 0;
        int busy_cyc = 0;
        int val;
        val = model(d);
        set_digits(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 1);
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            if (poke_at > 0 && lat == poke_at) begin
                set_digits(24'h999999);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(lat), 20);
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 20);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_busy_at_done"}, 32'(busy), 0);
        check({tag, "_data"}, 32'(data), 32'(val));
        exp_data = val;
    endtask

    task automatic run_invalid(input logic [23:0] d, input string tag);
        set_digits(d);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_err"}, 32'(err), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_data_kept"}, 32'(data), 32'(exp_data));
        tick();
        check({tag, "_done_drop"}, 32'(done), 0);
        check({tag, "_err_drop"}, 32'(err), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        int extra_done;
        logic [23:0] d;

        #5;
        check("rst_data", 32'(data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        #20 sys_rst_n = 1'b1;
        tick();

        run_valid(24'h999999, "all9", 0);
        tick();
        check("all9_done_one_cycle", 32'(done), 0);

        run_valid(24'h000000, "all0", 0);
        tick();
        run_valid(24'h000010, "ten", 0);
        tick();

        // A start during the conversion must neither restart nor queue a second one.
        run_valid(24'h123456, "ignore", 5);
        tick();
        check("ignore_done_drop", 32'(done), 0);
        check("ignore_no_restart", 32'(busy), 0);
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) extra_done++;
        end
        check("ignore_single_done", 32'(extra_done), 0);
        check("ignore_data", 32'(data), 123456);

        run_invalid(24'h1234A6, "bad_ten");

        // Reset partway through a conversion.
        set_digits(24'h654321);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        check("mid_busy_before_rst", 32'(busy), 1);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_err", 32'(err), 0);
        repeat (3) tick();
        sys_rst_n = 1'b1;
        exp_data = 0;
        extra_done = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done || busy) extra_done++;
        end
        check("midrst_no_activity", 32'(extra_done), 0);
        run_valid(24'h000001, "after_rst", 0);
        tick();

        // Back-to-back: second start issued in the done cycle of the first.
        run_valid(24'h000042, "b2b_a", 0);
        run_valid(24'h100000, "b2b_b", 0);
        tick();

        for (int n = 0; n < 8; n++) begin
            run_valid(rand_valid(), $sformatf("rnd%0d", n), 0);
            tick();
        end
        for (int n = 0; n < 4; n++) begin
            d = rand_valid();
            d[4*$urandom_range(0, 5) +: 4] = 4'($urandom_range(10, 15));
            run_invalid(d, $sformatf("rnd_bad%0d", n));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential six-digit 8421 BCD to 20-bit binary converter, the inverse of the team's binary-to-BCD block. It uses reverse double-dabble: shift right, then subtract 3 from every BCD digit ≥ 8, one step per clock. It sits between digit-entry logic (keypad or UART decimal input) and the datapath that consumes binary values. It operates on a start/done handshake and does not run freely.

## Interface
- No parameters: fixed at 6 digits and 20 output bits (999999 < 2^20).
- sys_clk  in  1  system clock, 50 MHz; one clock domain only
- sys_rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request; digits are sampled on the same edge
- unit  in  4  ones BCD digit
- ten  in  4  tens BCD digit
- hun  in  4  hundreds BCD digit
- tho  in  4  thousands BCD digit
- t_tho  in  4  ten-thousands BCD digit
- h_hun  in  4  hundred-thousands BCD digit
- data  out  20  converted binary result, registered
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse marking the end of a request
- err  out  1  one-cycle pulse together with done when the request held an invalid digit

## Operation
- States: IDLE and CONV.
- Internal 44-bit shift register {bcd[23:0], bin[19:0]} and a 5-bit step counter.
- IDLE with start=1, all digits ≤ 9:
  - load the register with {h_hun,t_tho,tho,hun,ten,unit,20'b0};
  - clear the counter, set busy=1, go to CONV.
- IDLE with start=1, any digit > 9:
  - stay in IDLE; busy stays 0;
  - done=1 and err=1 for one cycle;
  - data holds its previous value.
- CONV, each clock:
  - step 1: shift the whole register right by 1 (logical, MSB fills 0);
  - step 2: on the shifted value, each of the six 4-bit BCD fields that is ≥ 8 is reduced by 3 (modulo-16 arithmetic, no borrow between fields);
  - both steps complete in one cycle;
  - the counter increments.
- Counter = 19 (20th step):
  - data <= bin[19:0] of the result after that step;
  - done=1, busy=0, go to IDLE.
- start while busy=1 is ignored. It is not queued and does not change the digits being converted.
- Input digits only need to be stable on the start edge.
- err is only asserted with done. A valid conversion always drives err=0.

## Timing
- Reset values: data=0, busy=0, done=0, err=0, state IDLE, counter=0, shift register=0.
- Reset mid-conversion aborts immediately. No done pulse is generated, and data returns to 0.
- Valid request (start sampled on edge T):
  - busy high from T through the T+20 edge;
  - data updated and done high in the cycle following edge T+20;
  - latency from start to done is 20 clocks.
- Invalid request: done=err=1 in the cycle following edge T, a latency of 1 clock.
- Back-to-back: start is accepted in the cycle where done=1, because the block is already in IDLE. Peak throughput is one conversion per 21 clocks.
- done and err are registered. They stay high for exactly one cycle and then return to 0.
- data is stable from one done to the next. It changes only on a valid completion or on reset.

## Test plan
- Digits 9,9,9,9,9,9 with start -> busy for 20 cycles, then data=20'hF423F (999999), done=1, err=0 for one cycle.
- Digits all 0 -> data=0 after 20 cycles, done pulse, err=0. Then digits 0,0,0,0,1,0 (value 10) -> data=20'h0000A.
- Digits h_hun..unit = 1,2,3,4,5,6 -> data=20'h1E240 (123456). Pulse start again during busy with 9,9,9,9,9,9 -> ignored, result still 123456, only one done.
- ten=4'hA with other digits valid -> done=err=1 on the next cycle, busy never asserted, data keeps the previous result (123456).
- Assert sys_rst_n=0 at step 10 of a conversion of 654321 -> all outputs 0 immediately, no done. After release, a new start with 0,0,0,0,0,1 -> data=1 after 20 cycles.
- Back-to-back: start 000042, then start 100000 in the done cycle -> data=42 with done, then data=20'h186A0 after 20 more cycles. Check busy=0 for exactly the one done cycle between them.
